// File: rtl/output_buf.sv
// Memory-mapped output bank: LED and HEX registers, an LCD command register
// driving a timed enable-pulse sequencer, and combinational read-back.
module output_buf #(
    parameter int LCD_SETUP = 2,
    parameter int LCD_PULSE = 4,
    parameter int LCD_HOLD  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_en,
    input  logic [7:0]  i_addr,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_bmask,
    output logic [31:0] o_ld_data,
    output logic [16:0] o_io_ledr,
    output logic [7:0]  o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [16:0] r_ledr;
    logic [7:0]  r_ledg;
    logic [6:0]  r_hex [8];
    logic [7:0]  r_lcd_data;
    logic        r_lcd_rs;
    logic        r_lcd_en;
    logic        r_lcd_on;
    logic        r_overrun;

    logic [5:0]  w_word;
    logic        w_sel_ledr;
    logic        w_sel_ledg;
    logic        w_sel_hex_lo;
    logic        w_sel_hex_hi;
    logic        w_sel_cmd;
    logic        w_sel_stat;
    logic        w_trigger;
    logic        w_busy;
    logic        w_unused;

    assign w_word       = i_addr[7:2];
    assign w_sel_ledr   = (w_word == 6'h00);
    assign w_sel_ledg   = (w_word == 6'h04);
    assign w_sel_hex_lo = (w_word == 6'h08);
    assign w_sel_hex_hi = (w_word == 6'h09);
    assign w_sel_cmd    = (w_word == 6'h0C);
    assign w_sel_stat   = (w_word == 6'h0D);
    assign w_trigger    = i_wr_en & w_sel_cmd & i_bmask[0];
    assign w_busy       = (r_state != S_IDLE);
    assign w_unused     = ^{i_addr[1:0], i_st_data[23], i_st_data[15], i_st_data[7]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ledr <= '0;
            r_ledg <= '0;
            for (int i = 0; i < 8; i++) r_hex[i] <= 7'h7F;
        end else if (i_wr_en) begin
            if (w_sel_ledr) begin
                if (i_bmask[0]) r_ledr[7:0]  <= i_st_data[7:0];
                if (i_bmask[1]) r_ledr[15:8] <= i_st_data[15:8];
                if (i_bmask[2]) r_ledr[16]   <= i_st_data[16];
            end
            if (w_sel_ledg && i_bmask[0]) r_ledg <= i_st_data[7:0];
            for (int i = 0; i < 4; i++) begin
                if (w_sel_hex_lo && i_bmask[i]) r_hex[i]     <= i_st_data[8*i +: 7];
                if (w_sel_hex_hi && i_bmask[i]) r_hex[i + 4] <= i_st_data[8*i +: 7];
            end
        end
    end

    // LCD sequencer; the overrun set is written last so it beats a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lcd_data <= '0;
            r_lcd_rs   <= 1'b0;
            r_lcd_en   <= 1'b0;
            r_lcd_on   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (i_wr_en && w_sel_cmd && i_bmask[3]) r_lcd_on <= i_st_data[31];
            if (i_wr_en && w_sel_stat && i_bmask[0] && i_st_data[1]) r_overrun <= 1'b0;
            if (w_trigger && w_busy) r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_lcd_data <= i_st_data[7:0];
                        r_lcd_rs   <= i_st_data[8];
                        r_cnt      <= 16'(LCD_SETUP);
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == 16'd1) begin
                        r_cnt    <= 16'(LCD_PULSE);
                        r_lcd_en <= 1'b1;
                        r_state  <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == 16'd1) begin
                        r_cnt    <= 16'(LCD_HOLD);
                        r_lcd_en <= 1'b0;
                        r_state  <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == 16'd1) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_lcd_en <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_ld_data = '0;
        case (w_word)
            6'h00:   o_ld_data = {15'b0, r_ledr};
            6'h04:   o_ld_data = {24'b0, r_ledg};
            6'h08:   o_ld_data = {1'b0, r_hex[3], 1'b0, r_hex[2], 1'b0, r_hex[1], 1'b0, r_hex[0]};
            6'h09:   o_ld_data = {1'b0, r_hex[7], 1'b0, r_hex[6], 1'b0, r_hex[5], 1'b0, r_hex[4]};
            6'h0C:   o_ld_data = {r_lcd_on, 22'b0, r_lcd_rs, r_lcd_data};
            6'h0D:   o_ld_data = {30'b0, r_overrun, w_busy};
            default: o_ld_data = '0;
        endcase
    end

    assign o_io_ledr  = r_ledr;
    assign o_io_ledg  = r_ledg;
    assign o_io_hex0  = r_hex[0];
    assign o_io_hex1  = r_hex[1];
    assign o_io_hex2  = r_hex[2];
    assign o_io_hex3  = r_hex[3];
    assign o_io_hex4  = r_hex[4];
    assign o_io_hex5  = r_hex[5];
    assign o_io_hex6  = r_hex[6];
    assign o_io_hex7  = r_hex[7];
    assign o_lcd_data = r_lcd_data;
    assign o_lcd_rs   = r_lcd_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_lcd_en;
    assign o_lcd_on   = r_lcd_on;

endmodule

// File: tb/tb_output_buf.sv
// Bench for output_buf: a cycle-indexed model of the register bank and LCD
// timing windows, checked every cycle, plus directed literal expectations.
module tb_output_buf;

    localparam int S = 2;
    localparam int P = 4;
    localparam int H = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_wr_en = 1'b0;
    logic [7:0]  i_addr = '0;
    logic [31:0] i_st_data = '0;
    logic [3:0]  i_bmask = '0;
    logic [31:0] o_ld_data;
    logic [16:0] o_io_ledr;
    logic [7:0]  o_io_ledg;
    logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
    logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;

    output_buf #(.LCD_SETUP(S), .LCD_PULSE(P), .LCD_HOLD(H)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_addr(i_addr),
        .i_st_data(i_st_data), .i_bmask(i_bmask), .o_ld_data(o_ld_data),
        .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
        .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1), .o_io_hex2(o_io_hex2), .o_io_hex3(o_io_hex3),
        .o_io_hex4(o_io_hex4), .o_io_hex5(o_io_hex5), .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7),
        .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on)
    );

    always #5 i_clk = ~i_clk;

    logic [6:0] hexOut [8];
    assign hexOut[0] = o_io_hex0;
    assign hexOut[1] = o_io_hex1;
    assign hexOut[2] = o_io_hex2;
    assign hexOut[3] = o_io_hex3;
    assign hexOut[4] = o_io_hex4;
    assign hexOut[5] = o_io_hex5;
    assign hexOut[6] = o_io_hex6;
    assign hexOut[7] = o_io_hex7;

    int nChecks = 0;
    int nFail = 0;

    // Model state: register contents plus the cycle index at which the latest
    // LCD sequence was accepted; en/busy are derived from distance to it.
    logic [16:0] mLedr;
    logic [7:0]  mLedg;
    logic [6:0]  mHex [8];
    logic [7:0]  mLcdData;
    logic        mRs, mOn, mOverrun;
    int          cyc = 0;
    int          tStart = -100;
    bit          modelValid = 1'b0;

    function automatic bit modelBusy();
        int d = cyc - tStart;
        return (d >= 1) && (d <= S + P + H);
    endfunction

    function automatic bit modelEn();
        int d = cyc - tStart;
        return (d >= S + 1) && (d <= S + P);
    endfunction

    function automatic logic [31:0] modelRead(input logic [7:0] a);
        logic [31:0] r = '0;
        case (a[7:2])
            6'h00: r = {15'b0, mLedr};
            6'h04: r = {24'b0, mLedg};
            6'h08: for (int i = 0; i < 4; i++) r[8*i +: 8] = {1'b0, mHex[i]};
            6'h09: for (int i = 0; i < 4; i++) r[8*i +: 8] = {1'b0, mHex[i + 4]};
            6'h0C: r = {mOn, 22'b0, mRs, mLcdData};
            6'h0D: r = {30'b0, mOverrun, modelBusy()};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Model update at each active edge, using the inputs held during the cycle.
    always @(posedge i_clk) begin
        bit busyNow;
        busyNow = modelBusy();
        if (i_rst) begin
            mLedr = '0;
            mLedg = '0;
            for (int i = 0; i < 8; i++) mHex[i] = 7'h7F;
            mLcdData = '0;
            mRs = 1'b0;
            mOn = 1'b0;
            mOverrun = 1'b0;
            tStart = -100;
            modelValid = 1'b1;
        end else if (i_wr_en) begin
            case (i_addr[7:2])
                6'h00: begin
                    if (i_bmask[0]) mLedr[7:0]  = i_st_data[7:0];
                    if (i_bmask[1]) mLedr[15:8] = i_st_data[15:8];
                    if (i_bmask[2]) mLedr[16]   = i_st_data[16];
                end
                6'h04: if (i_bmask[0]) mLedg = i_st_data[7:0];
                6'h08: for (int i = 0; i < 4; i++) if (i_bmask[i]) mHex[i] = i_st_data[8*i +: 7];
                6'h09: for (int i = 0; i < 4; i++) if (i_bmask[i]) mHex[i + 4] = i_st_data[8*i +: 7];
                6'h0C: begin
                    if (i_bmask[3]) mOn = i_st_data[31];
                    if (i_bmask[0]) begin
                        if (busyNow) begin
                            mOverrun = 1'b1;
                        end else begin
                            mLcdData = i_st_data[7:0];
                            mRs = i_st_data[8];
                            tStart = cyc;
                        end
                    end
                end
                6'h0D: if (i_bmask[0] && i_st_data[1]) mOverrun = 1'b0;
                default: ;
            endcase
        end
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge i_clk) begin
        if (modelValid) begin
            checkOutput("ledr", {15'b0, o_io_ledr}, {15'b0, mLedr});
            checkOutput("ledg", {24'b0, o_io_ledg}, {24'b0, mLedg});
            for (int i = 0; i < 8; i++)
                checkOutput($sformatf("hex%0d", i), {25'b0, hexOut[i]}, {25'b0, mHex[i]});
            checkOutput("lcd_data", {24'b0, o_lcd_data}, {24'b0, mLcdData});
            checkOutput("lcd_rs", {31'b0, o_lcd_rs}, {31'b0, mRs});
            checkOutput("lcd_rw", {31'b0, o_lcd_rw}, 32'd0);
            checkOutput("lcd_en", {31'b0, o_lcd_en}, {31'b0, modelEn()});
            checkOutput("lcd_on", {31'b0, o_lcd_on}, {31'b0, mOn});
            checkOutput("ld_data", o_ld_data, modelRead(i_addr));
        end
    end

    task automatic applyStimulus(input bit rst, input bit wr, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [3:0] mask);
        @(posedge i_clk);
        #1;
        i_rst = rst;
        i_wr_en = wr;
        i_addr = addr;
        i_st_data = data;
        i_bmask = mask;
    endtask

    task automatic idle(input logic [7:0] addr);
        applyStimulus(1'b0, 1'b0, addr, 32'h0, 4'h0);
    endtask

    logic [7:0]  rdAddr [7];
    logic [31:0] rdExp  [7];

    initial begin
        rdAddr = '{8'h00, 8'h10, 8'h20, 8'h24, 8'h30, 8'h34, 8'h40};
        rdExp  = '{32'h0, 32'h0, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h0, 32'h0, 32'h0};

        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);

        // Reset state read-back of every offset.
        for (int i = 0; i < 7; i++) begin
            idle(rdAddr[i]);
            @(negedge i_clk);
            checkOutput("rst_read", o_ld_data, rdExp[i]);
        end
        checkOutput("rst_hex0", {25'b0, o_io_hex0}, 32'h7F);
        checkOutput("rst_en", {31'b0, o_lcd_en}, 32'h0);

        // LEDR byte-lane writes.
        applyStimulus(1'b0, 1'b1, 8'h00, 32'h0001ABCD, 4'b0001);
        idle(8'h00);
        @(negedge i_clk);
        checkOutput("ledr_lane0", {15'b0, o_io_ledr}, 32'h000000CD);
        applyStimulus(1'b0, 1'b1, 8'h00, 32'h0001ABCD, 4'b1111);
        idle(8'h03);
        @(negedge i_clk);
        checkOutput("ledr_full", {15'b0, o_io_ledr}, 32'h0001ABCD);
        checkOutput("ledr_read", o_ld_data, 32'h0001ABCD);
        applyStimulus(1'b0, 1'b1, 8'h00, 32'h00FE0000, 4'b0100);
        idle(8'h00);
        @(negedge i_clk);
        checkOutput("ledr_bit16", {15'b0, o_io_ledr}, 32'h0000ABCD);

        // HEX lane writes leave unmasked digits blank.
        applyStimulus(1'b0, 1'b1, 8'h20, 32'h40792440, 4'b0110);
        idle(8'h20);
        @(negedge i_clk);
        checkOutput("hex1", {25'b0, o_io_hex1}, 32'h24);
        checkOutput("hex2", {25'b0, o_io_hex2}, 32'h79);
        checkOutput("hex0_keep", {25'b0, o_io_hex0}, 32'h7F);
        checkOutput("hex3_keep", {25'b0, o_io_hex3}, 32'h7F);
        checkOutput("hex_read", o_ld_data, 32'h7F79247F);
        applyStimulus(1'b0, 1'b1, 8'h24, 32'h01020304, 4'b1001);

        // LEDG plus a write to an unmapped offset.
        applyStimulus(1'b0, 1'b1, 8'h10, 32'h000000A5, 4'b0001);
        applyStimulus(1'b0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'b1111);
        idle(8'h40);
        @(negedge i_clk);
        checkOutput("ledg", {24'b0, o_io_ledg}, 32'hA5);
        checkOutput("unmapped_read", o_ld_data, 32'h0);

        // Single LCD sequence: en during T+3..T+6, busy through T+8.
        applyStimulus(1'b0, 1'b1, 8'h30, 32'h80000138, 4'b1111);
        for (int k = 1; k <= 9; k++) begin
            idle(8'h34);
            @(negedge i_clk);
            checkOutput($sformatf("seqA_en_k%0d", k), {31'b0, o_lcd_en}, (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
            checkOutput($sformatf("seqA_busy_k%0d", k), o_ld_data, (k <= 8) ? 32'd1 : 32'd0);
            if (k == 1) begin
                checkOutput("seqA_data", {24'b0, o_lcd_data}, 32'h38);
                checkOutput("seqA_rs", {31'b0, o_lcd_rs}, 32'h1);
                checkOutput("seqA_on", {31'b0, o_lcd_on}, 32'h1);
            end
        end

        // Overrun, clear, and back-to-back trigger at T+9.
        applyStimulus(1'b0, 1'b1, 8'h30, 32'h80000138, 4'b1111);
        for (int k = 1; k <= 3; k++) idle(8'h34);
        applyStimulus(1'b0, 1'b1, 8'h30, 32'h00000055, 4'b0001);
        applyStimulus(1'b0, 1'b1, 8'h34, 32'h00000002, 4'b0001);
        @(negedge i_clk);
        checkOutput("ovr_set", o_ld_data, 32'h3);
        checkOutput("ovr_data_kept", {24'b0, o_lcd_data}, 32'h38);
        idle(8'h34);
        @(negedge i_clk);
        checkOutput("ovr_clear", o_ld_data, 32'h1);
        idle(8'h34);
        idle(8'h34);
        applyStimulus(1'b0, 1'b1, 8'h30, 32'h000001AA, 4'b0001);
        @(negedge i_clk);
        checkOutput("cmd_read", o_ld_data, 32'h80000138);
        idle(8'h34);
        @(negedge i_clk);
        checkOutput("seqC_busy", o_ld_data, 32'h1);
        checkOutput("seqC_data", {24'b0, o_lcd_data}, 32'hAA);
        for (int k = 0; k < 9; k++) idle(8'h34);

        // On-only updates never start a sequence.
        applyStimulus(1'b0, 1'b1, 8'h30, 32'h00000000, 4'b1000);
        idle(8'h34);
        @(negedge i_clk);
        checkOutput("on_off", {31'b0, o_lcd_on}, 32'h0);
        checkOutput("on_nobusy", o_ld_data, 32'h0);
        applyStimulus(1'b0, 1'b1, 8'h30, 32'h80000000, 4'b1000);
        idle(8'h30);
        @(negedge i_clk);
        checkOutput("on_again", o_ld_data, 32'h800001AA);

        // Reset mid-pulse, with a coincident store that must be discarded.
        applyStimulus(1'b0, 1'b1, 8'h30, 32'h800001F0, 4'b1111);
        for (int k = 1; k <= 3; k++) idle(8'h34);
        applyStimulus(1'b1, 1'b1, 8'h00, 32'hFFFFFFFF, 4'b1111);
        @(negedge i_clk);
        checkOutput("pre_rst_en", {31'b0, o_lcd_en}, 32'h1);
        idle(8'h34);
        @(negedge i_clk);
        checkOutput("rst_mid_en", {31'b0, o_lcd_en}, 32'h0);
        checkOutput("rst_mid_stat", o_ld_data, 32'h0);
        checkOutput("rst_mid_data", {24'b0, o_lcd_data}, 32'h0);
        checkOutput("rst_mid_on", {31'b0, o_lcd_on}, 32'h0);
        checkOutput("rst_mid_ledr", {15'b0, o_io_ledr}, 32'h0);
        checkOutput("rst_mid_hex7", {25'b0, o_io_hex7}, 32'h7F);
        for (int k = 0; k < 4; k++) idle(8'h00);
        @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/output_buf.md
Name: output_buf

Overview:
- Memory-mapped output peripheral bank, directly downstream of the LSU address decoder. Its write enable is the decoder's output-buffer enable, active for stores to 0x7000–0x70FF.
- Holds the red/green LED registers, eight 7-segment HEX digits, and an LCD command register.
- Drives a timed LCD enable-pulse sequencer and provides combinational read-back to the LSU load mux.

Parameters:
- LCD_SETUP, 2, cycles data/rs are held stable before o_lcd_en rises (≥1).
- LCD_PULSE, 4, cycles o_lcd_en stays high (≥1).
- LCD_HOLD, 2, cycles after o_lcd_en falls before the sequencer is idle again (≥1).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_wr_en  in  1  store strobe from the decoder output-buffer enable; one write per asserted cycle.
- i_addr  in  8  byte offset within the 0x70xx page (i_lsu_addr[7:0]).
- i_st_data  in  32  store data.
- i_bmask  in  4  byte enables; bit n writes byte n.
- o_ld_data  out  32  combinational read-back of the register selected by i_addr.
- o_io_ledr  out  17  red LEDs.
- o_io_ledg  out  8  green LEDs.
- o_io_hex0..o_io_hex7  out  7 each  segment patterns, active-low segments as stored.
- o_lcd_data  out  8  LCD data bus.
- o_lcd_rs  out  1  LCD register select.
- o_lcd_rw  out  1  tied 0.
- o_lcd_en  out  1  LCD enable pulse.
- o_lcd_on  out  1  LCD power/backlight.

Behaviour:
Register map (offsets are word-aligned; i_addr[1:0] is ignored):
- 0x00 LEDR[16:0]; upper bits read 0.
- 0x10 LEDG[7:0].
- 0x20 HEX0..HEX3, one per byte lane, bits [6:0] each; bit 7 of each lane reads 0.
- 0x24 HEX4..HEX7, same layout.
- 0x30 LCD_CMD: [7:0] data, [8] rs, [31] on.
- 0x34 LCD_STAT (read-only): [0] busy, [1] overrun (sticky).
- Any other offset: writes ignored, reads 0.

Register writes:
- Registers update on the clock edge when i_wr_en=1. Only byte lanes with i_bmask set are written.
- Write latency is one cycle: outputs reflect new values the cycle after the store.
- o_ld_data is combinational from current register state, so there is no write-through forwarding in the same cycle.

LCD sequencer:
- Triggered by a write to 0x30 with i_bmask[0]=1.
- In IDLE the trigger captures data and rs into o_lcd_data/o_lcd_rs. If i_bmask[3]=1, it also captures on (bit 31); otherwise on is unchanged.
- States: IDLE → SETUP (LCD_SETUP cycles, en=0) → PULSE (LCD_PULSE cycles, en=1) → HOLD (LCD_HOLD cycles, en=0) → IDLE.
- Each state uses a down-counter loaded on entry; the state advances when the counter reaches 1.
- busy=1 in every state except IDLE.
- A trigger while busy:
  - data/rs are not changed and the sequence is not restarted;
  - overrun is set;
  - the on bit still updates if i_bmask[3]=1.
- A write to 0x34 with i_bmask[0]=1 and i_st_data[1]=1 clears overrun. If a clear and a new overrun occur in the same cycle, the set wins.
- A write to 0x30 with i_bmask[0]=0 never triggers the sequence (on-only update allowed).
- Trigger on the exact cycle the sequencer returns to IDLE: the FSM is already IDLE that cycle, so the trigger is accepted. The next sequence starts with no gap after HOLD.

Reset (i_rst=1 at clock edge, including mid-sequence):
- All registers are cleared to 0 and HEX outputs to 7'h7F (blank).
- FSM returns to IDLE; o_lcd_en=0, o_lcd_data=0, o_lcd_rs=0, o_lcd_on=0, busy=0, overrun=0.
- A store coincident with reset is discarded.

Test Plan:
- Reset then read all offsets → LEDR/LEDG/LCD_STAT read 0; HEX outputs 7'h7F; o_lcd_en=0.
- Store 0x0001_ABCD to 0x00 with bmask 4'b0001 → o_io_ledr=0x000CD next cycle. Then bmask 4'b1111 → 0x1ABCD; o_ld_data @0x00 = 0x0001ABCD.
- Store 0x4079_2440 to 0x20 with bmask 4'b0110 (HEX0..3 previously 7'h7F) → hex1=7'h24, hex2=7'h79; hex0 and hex3 unchanged at 7'h7F.
- Store 0x8000_0138 to 0x30 with bmask 4'b1111 at cycle T, default parameters:
  - o_lcd_data=0x38, rs=1, on=1 from T+1;
  - o_lcd_en=1 exactly during cycles T+3..T+6;
  - busy reads 1 through T+8 and 0 at T+9.
- Second LCD store at T+4 → o_lcd_data stays 0x38, overrun reads 1. Store 0x2 to 0x34 → overrun 0. A trigger at T+9 starts a new sequence.
- Assert i_rst at T+4 mid-pulse → o_lcd_en=0, busy=0, all outputs at reset values on the next cycle.
